mpsoc3d_riscv_shell: RTL and testbench
======================================

Name: mpsoc3d_riscv_shell

Overview:
System-level shell of the 3D RISC-V MPSoC; sits between the compute tiles, the host debug link and the external memory bus.
- Host side: a GLIP 16-bit FIFO channel pair drives a small debug command decoder, which controls system reset and CPU stall and reports per-tile termination status.
- Bus side: the NUMCTS compute-tile AHB-Lite masters share one external AHB-Lite port through a round-robin arbiter.

Parameters:
- NUMCTS, 8, number of compute tiles / AHB masters (1..8)
- XLEN, 32, AHB address/data width
- GLIP_WIDTH, 16, GLIP channel data width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- glip_in_data  in  16  host→SoC word
- glip_in_valid  in  1  host word valid
- glip_in_ready  out  1  shell accepts word
- glip_out_data  out  16  SoC→host word
- glip_out_valid  out  1  response valid
- glip_out_ready  in  1  host accepts response
- termination  in  NUMCTS  per-tile program-terminated flags
- rst_sys  out  1  rst OR logic_rst
- rst_cpu  out  1  rst OR logic_rst
- cpu_stall  out  1  stall all cores
- tile_hsel, tile_hwrite, tile_hmastlock  in  NUMCTS  per-tile AHB controls
- tile_haddr, tile_hwdata  in  NUMCTS*XLEN  flattened address/data, tile k at [k*XLEN +: XLEN]
- tile_hsize, tile_hburst  in  NUMCTS*3
- tile_hprot  in  NUMCTS*4
- tile_htrans  in  NUMCTS*2
- tile_hrdata  out  NUMCTS*XLEN
- tile_hready, tile_hresp  out  NUMCTS
- ahb4_ext_hsel_i, ahb4_ext_hwrite_i, ahb4_ext_hmastlock_i  out  1  external bus controls (codebase naming, driven by shell)
- ahb4_ext_haddr_i, ahb4_ext_hwdata_i  out  XLEN
- ahb4_ext_hsize_i, ahb4_ext_hburst_i  out  3
- ahb4_ext_hprot_i  out  4
- ahb4_ext_htrans_i  out  2
- ahb4_ext_hrdata_o  in  XLEN  external read data
- ahb4_ext_hready_o, ahb4_ext_hresp_o  in  1

Behaviour:
- Clock and reset: single clock; all flops reset asynchronously on rst=1.
- Reset values: logic_rst=0, cpu_stall=0, glip_out_valid=0, glip_out_data=0, grant owner=tile 0 idle, ext htrans=IDLE, ext hsel=0.
- GLIP input handshake:
  - glip_in_ready=1 whenever no response is pending (glip_out_valid=0).
  - A word is consumed when valid&&ready; it is decoded in the same cycle and takes effect the next cycle.
- GLIP opcodes, op=[15:12]:
  - 0x1: logic_rst <= bit0.
  - 0x2: cpu_stall <= bit0.
  - 0x3: status request; response {4'h3, 4'h0, 8'(termination)} presented next cycle.
  - 0x4: echo; response = input word.
  - Any other opcode: response 16'hFFFF.
  - Opcodes 0x1 and 0x2 produce no response.
- GLIP output: glip_out_valid holds until glip_out_ready. The response is dropped only on that handshake; the next request can be accepted in the following cycle.
- Arbiter request and grant:
  - Tile k requests when tile_hsel[k]=1 and tile_htrans[k]=NONSEQ.
  - Round-robin priority starts at (last owner + 1) mod NUMCTS.
  - Re-arbitration happens only when the current owner drives htrans=IDLE with hmastlock=0, and ahb4_ext_hready_o=1.
  - A locked owner keeps the bus regardless of other requests.
- Address phase: the owner's address-phase signals pass combinationally to ahb4_ext_*_i. With no owner, ext hsel=0 and htrans=IDLE.
- Data phase:
  - A data-phase owner register captures the owner when hready=1.
  - hrdata, hresp and hready route to the data-phase owner only.
  - Non-owner tiles with a pending request see tile_hready=0 and hresp=0; idle non-owners see hready=1.
  - The data-phase owner's tile_hwdata drives ahb4_ext_hwdata_i.
- Simultaneous requests from tiles 0 and 1 after reset: tile 0 wins first.
- Reset mid-transfer: ownership clears and the external bus goes IDLE.

Optional Feature:
- MPSOC3D_DEBUG_EN defined: GLIP decoder present as described.
- Undefined:
  - glip_in_ready=1 (words are discarded), glip_out_valid=0.
  - logic_rst=0 and cpu_stall=0 constantly; rst_sys=rst_cpu=rst.

Decomposition:
- Package mpsoc3d_riscv_shell_pkg: HTRANS constants (IDLE, BUSY, NONSEQ, SEQ); GLIP opcode constants; error word 16'hFFFF.
- Sub-module mpsoc3d_riscv_ahb_arbiter: round-robin grant plus data-phase owner tracking.
- The GLIP decoder stays inline.

Test Plan:
- Reset: assert rst → rst_sys=1, cpu_stall=0, glip_out_valid=0, ext htrans=IDLE.
- GLIP 16'h1001 then 16'h1000 → rst_sys high for the interval between the two words, then low; no glip_out response.
- termination=8'b0000_0101, GLIP 16'h3000 → glip_out_data=16'h3005. Hold glip_out_ready=0 for 3 cycles → valid stays 1, glip_in_ready=0.
- GLIP 16'h7ABC → response 16'hFFFF; GLIP 16'h4ABC → echo 16'h4ABC.
- Tiles 0 and 2 request NONSEQ at haddr 0x100 and 0x200 simultaneously:
  - ext haddr 0x100 first, then 0x200.
  - Tile 2 sees hready=0 until granted.
  - Read data 0xDEADBEEF reaches tile 0 only.
- Tile 1 with hmastlock=1 holds the bus while tile 3 requests → no grant to tile 3 until hmastlock=0 and IDLE.

Source files
------------

// File: rtl/mpsoc3d_riscv_shell_pkg.sv
// Shared constants for the 3D RISC-V MPSoC shell: AHB transfer types and
// GLIP debug opcodes.
package mpsoc3d_riscv_shell_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [3:0] GLIP_OP_LOGIC_RST = 4'h1;
  localparam logic [3:0] GLIP_OP_CPU_STALL = 4'h2;
  localparam logic [3:0] GLIP_OP_STATUS    = 4'h3;
  localparam logic [3:0] GLIP_OP_ECHO      = 4'h4;

  localparam logic [15:0] GLIP_ERR_WORD = 16'hFFFF;

endpackage

// File: rtl/mpsoc3d_riscv_ahb_arbiter.sv
// Round-robin AHB-Lite arbiter for the compute tiles: registered address-phase
// grant plus data-phase owner tracking.
module mpsoc3d_riscv_ahb_arbiter
  import mpsoc3d_riscv_shell_pkg::*;
#(
  parameter int unsigned NUMCTS = 8,
  localparam int unsigned IW = (NUMCTS > 1) ? $clog2(NUMCTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUMCTS-1:0]   tile_hsel,
  input  logic [NUMCTS-1:0]   tile_hmastlock,
  input  logic [2*NUMCTS-1:0] tile_htrans,
  input  logic                ext_hready,
  output logic [NUMCTS-1:0]   tile_req,
  output logic                owner_valid,
  output logic [IW-1:0]       owner,
  output logic                data_valid,
  output logic [IW-1:0]       data_owner
);

  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic          win_found;
  logic [1:0]    owner_trans;
  logic          rearb;

  always_comb begin
    tile_req = '0;
    for (int unsigned k = 0; k < NUMCTS; k++) begin
      tile_req[k] = tile_hsel[k] && (tile_htrans[2*k +: 2] == HTRANS_NONSEQ);
    end
  end

  // Scan starts one past the last granted tile; last resets to NUMCTS-1 so
  // tile 0 has top priority out of reset.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win       = '0;
    for (int unsigned i = 1; i <= NUMCTS; i++) begin
      cand = (32'(last) + i) % NUMCTS;
      if (!win_found && tile_req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win       = cand[IW-1:0];
      end
    end
  end

  assign owner_trans = tile_htrans[2*owner +: 2];
  assign rearb = ext_hready &&
                 (!owner_valid || (owner_trans == HTRANS_IDLE && !tile_hmastlock[owner]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_valid <= 1'b0;
      owner       <= '0;
      last        <= IW'(NUMCTS - 1);
      data_valid  <= 1'b0;
      data_owner  <= '0;
    end else begin
      if (rearb) begin
        owner_valid <= win_found;
        if (win_found) begin
          owner <= win;
          last  <= win;
        end
      end
      if (ext_hready) begin
        data_valid <= owner_valid;
        data_owner <= owner;
      end
    end
  end

endmodule

// File: rtl/mpsoc3d_riscv_shell.sv
// System shell of the 3D RISC-V MPSoC: GLIP debug decoder (MPSOC3D_DEBUG_EN)
// and shared external AHB-Lite port for the compute tiles.
module mpsoc3d_riscv_shell
  import mpsoc3d_riscv_shell_pkg::*;
#(
  parameter int unsigned NUMCTS     = 8,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned GLIP_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [GLIP_WIDTH-1:0]  glip_in_data,
  input  logic                   glip_in_valid,
  output logic                   glip_in_ready,
  output logic [GLIP_WIDTH-1:0]  glip_out_data,
  output logic                   glip_out_valid,
  input  logic                   glip_out_ready,
  input  logic [NUMCTS-1:0]      termination,
  output logic                   rst_sys,
  output logic                   rst_cpu,
  output logic                   cpu_stall,
  input  logic [NUMCTS-1:0]      tile_hsel,
  input  logic [NUMCTS-1:0]      tile_hwrite,
  input  logic [NUMCTS-1:0]      tile_hmastlock,
  input  logic [NUMCTS*XLEN-1:0] tile_haddr,
  input  logic [NUMCTS*XLEN-1:0] tile_hwdata,
  input  logic [NUMCTS*3-1:0]    tile_hsize,
  input  logic [NUMCTS*3-1:0]    tile_hburst,
  input  logic [NUMCTS*4-1:0]    tile_hprot,
  input  logic [NUMCTS*2-1:0]    tile_htrans,
  output logic [NUMCTS*XLEN-1:0] tile_hrdata,
  output logic [NUMCTS-1:0]      tile_hready,
  output logic [NUMCTS-1:0]      tile_hresp,
  output logic                   ahb4_ext_hsel_i,
  output logic                   ahb4_ext_hwrite_i,
  output logic                   ahb4_ext_hmastlock_i,
  output logic [XLEN-1:0]        ahb4_ext_haddr_i,
  output logic [XLEN-1:0]        ahb4_ext_hwdata_i,
  output logic [2:0]             ahb4_ext_hsize_i,
  output logic [2:0]             ahb4_ext_hburst_i,
  output logic [3:0]             ahb4_ext_hprot_i,
  output logic [1:0]             ahb4_ext_htrans_i,
  input  logic [XLEN-1:0]        ahb4_ext_hrdata_o,
  input  logic                   ahb4_ext_hready_o,
  input  logic                   ahb4_ext_hresp_o
);

  localparam int unsigned IW = (NUMCTS > 1) ? $clog2(NUMCTS) : 1;

  logic logic_rst;

`ifdef MPSOC3D_DEBUG_EN
  logic [3:0] glip_op;
  logic [7:0] term8;
  logic       glip_accept;

  assign glip_in_ready = !glip_out_valid;
  assign glip_accept   = glip_in_valid && glip_in_ready;
  assign glip_op       = glip_in_data[GLIP_WIDTH-1 -: 4];

  always_comb begin
    term8 = '0;
    term8[NUMCTS-1:0] = termination;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      logic_rst      <= 1'b0;
      cpu_stall      <= 1'b0;
      glip_out_valid <= 1'b0;
      glip_out_data  <= '0;
    end else begin
      if (glip_out_valid && glip_out_ready) begin
        glip_out_valid <= 1'b0;
      end
      // Accept is only possible with no response pending, so it never
      // collides with the drop above.
      if (glip_accept) begin
        case (glip_op)
          GLIP_OP_LOGIC_RST: logic_rst <= glip_in_data[0];
          GLIP_OP_CPU_STALL: cpu_stall <= glip_in_data[0];
          GLIP_OP_STATUS: begin
            glip_out_valid <= 1'b1;
            glip_out_data  <= {GLIP_OP_STATUS, 4'h0, term8};
          end
          GLIP_OP_ECHO: begin
            glip_out_valid <= 1'b1;
            glip_out_data  <= glip_in_data;
          end
          default: begin
            glip_out_valid <= 1'b1;
            glip_out_data  <= GLIP_ERR_WORD;
          end
        endcase
      end
    end
  end
`else
  logic unused_glip;

  assign glip_in_ready  = 1'b1;
  assign glip_out_valid = 1'b0;
  assign glip_out_data  = '0;
  assign logic_rst      = 1'b0;
  assign cpu_stall      = 1'b0;
  assign unused_glip    = ^{glip_in_data, glip_in_valid, glip_out_ready, termination};
`endif

  assign rst_sys = rst | logic_rst;
  assign rst_cpu = rst | logic_rst;

  logic [NUMCTS-1:0] tile_req;
  logic              owner_valid;
  logic [IW-1:0]     owner;
  logic              data_valid;
  logic [IW-1:0]     data_owner;

  mpsoc3d_riscv_ahb_arbiter #(
    .NUMCTS(NUMCTS)
  ) u_arbiter (
    .clk            (clk),
    .rst            (rst),
    .tile_hsel      (tile_hsel),
    .tile_hmastlock (tile_hmastlock),
    .tile_htrans    (tile_htrans),
    .ext_hready     (ahb4_ext_hready_o),
    .tile_req       (tile_req),
    .owner_valid    (owner_valid),
    .owner          (owner),
    .data_valid     (data_valid),
    .data_owner     (data_owner)
  );

  always_comb begin
    ahb4_ext_hsel_i      = 1'b0;
    ahb4_ext_hwrite_i    = 1'b0;
    ahb4_ext_hmastlock_i = 1'b0;
    ahb4_ext_haddr_i     = '0;
    ahb4_ext_hsize_i     = '0;
    ahb4_ext_hburst_i    = '0;
    ahb4_ext_hprot_i     = '0;
    ahb4_ext_htrans_i    = HTRANS_IDLE;
    if (owner_valid) begin
      ahb4_ext_hsel_i      = tile_hsel[owner];
      ahb4_ext_hwrite_i    = tile_hwrite[owner];
      ahb4_ext_hmastlock_i = tile_hmastlock[owner];
      ahb4_ext_haddr_i     = tile_haddr[owner*XLEN +: XLEN];
      ahb4_ext_hsize_i     = tile_hsize[owner*3 +: 3];
      ahb4_ext_hburst_i    = tile_hburst[owner*3 +: 3];
      ahb4_ext_hprot_i     = tile_hprot[owner*4 +: 4];
      ahb4_ext_htrans_i    = tile_htrans[owner*2 +: 2];
    end
    ahb4_ext_hwdata_i = data_valid ? tile_hwdata[data_owner*XLEN +: XLEN] : '0;
  end

  // The address-phase owner also needs the bus hready to see its address
  // accepted; a waiting requester is stalled even if it owns the data phase.
  always_comb begin
    logic is_owner;
    logic is_downer;
    is_owner    = 1'b0;
    is_downer   = 1'b0;
    tile_hrdata = '0;
    tile_hresp  = '0;
    tile_hready = '0;
    for (int unsigned k = 0; k < NUMCTS; k++) begin
      is_owner  = owner_valid && (owner == IW'(k));
      is_downer = data_valid && (data_owner == IW'(k));
      tile_hrdata[k*XLEN +: XLEN] = is_downer ? ahb4_ext_hrdata_o : '0;
      tile_hresp[k] = is_downer && ahb4_ext_hresp_o;
      if (is_owner) begin
        tile_hready[k] = ahb4_ext_hready_o;
      end else if (tile_req[k]) begin
        tile_hready[k] = 1'b0;
      end else if (is_downer) begin
        tile_hready[k] = ahb4_ext_hready_o;
      end else begin
        tile_hready[k] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpsoc3d_riscv_shell.sv
// Self-checking bench for mpsoc3d_riscv_shell: GLIP decoder (or its disabled
// form without MPSOC3D_DEBUG_EN) and the shared AHB-Lite arbiter.
module tb_mpsoc3d_riscv_shell;
  import mpsoc3d_riscv_shell_pkg::*;

  localparam int NUMCTS = 8;
  localparam int XLEN   = 32;
`ifdef MPSOC3D_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0]            glip_in_data = '0;
  logic                   glip_in_valid = 1'b0;
  logic                   glip_in_ready;
  logic [15:0]            glip_out_data;
  logic                   glip_out_valid;
  logic                   glip_out_ready = 1'b1;
  logic [NUMCTS-1:0]      termination = 8'b0000_0101;
  logic                   rst_sys, rst_cpu, cpu_stall;
  logic [NUMCTS-1:0]      tile_hsel = '0, tile_hwrite = '0, tile_hmastlock = '0;
  logic [NUMCTS*XLEN-1:0] tile_haddr = '0, tile_hwdata = '0;
  logic [NUMCTS*3-1:0]    tile_hsize = {NUMCTS{3'b010}}, tile_hburst = '0;
  logic [NUMCTS*4-1:0]    tile_hprot = {NUMCTS{4'h3}};
  logic [NUMCTS*2-1:0]    tile_htrans = '0;
  logic [NUMCTS*XLEN-1:0] tile_hrdata;
  logic [NUMCTS-1:0]      tile_hready, tile_hresp;
  logic                   ext_hsel, ext_hwrite, ext_hmastlock;
  logic [XLEN-1:0]        ext_haddr, ext_hwdata;
  logic [2:0]             ext_hsize, ext_hburst;
  logic [3:0]             ext_hprot;
  logic [1:0]             ext_htrans;
  logic [XLEN-1:0]        ext_hrdata = '0;
  logic                   ext_hready = 1'b1;
  logic                   ext_hresp = 1'b0;

  mpsoc3d_riscv_shell #(.NUMCTS(NUMCTS), .XLEN(XLEN), .GLIP_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .glip_in_data(glip_in_data), .glip_in_valid(glip_in_valid), .glip_in_ready(glip_in_ready),
    .glip_out_data(glip_out_data), .glip_out_valid(glip_out_valid), .glip_out_ready(glip_out_ready),
    .termination(termination), .rst_sys(rst_sys), .rst_cpu(rst_cpu), .cpu_stall(cpu_stall),
    .tile_hsel(tile_hsel), .tile_hwrite(tile_hwrite), .tile_hmastlock(tile_hmastlock),
    .tile_haddr(tile_haddr), .tile_hwdata(tile_hwdata), .tile_hsize(tile_hsize),
    .tile_hburst(tile_hburst), .tile_hprot(tile_hprot), .tile_htrans(tile_htrans),
    .tile_hrdata(tile_hrdata), .tile_hready(tile_hready), .tile_hresp(tile_hresp),
    .ahb4_ext_hsel_i(ext_hsel), .ahb4_ext_hwrite_i(ext_hwrite), .ahb4_ext_hmastlock_i(ext_hmastlock),
    .ahb4_ext_haddr_i(ext_haddr), .ahb4_ext_hwdata_i(ext_hwdata), .ahb4_ext_hsize_i(ext_hsize),
    .ahb4_ext_hburst_i(ext_hburst), .ahb4_ext_hprot_i(ext_hprot), .ahb4_ext_htrans_i(ext_htrans),
    .ahb4_ext_hrdata_o(ext_hrdata), .ahb4_ext_hready_o(ext_hready), .ahb4_ext_hresp_o(ext_hresp)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [XLEN-1:0] exp_addr_q[$];
  logic [15:0]     glip_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_tile(input int t, input logic sel, input logic [1:0] tr,
                          input logic [XLEN-1:0] addr, input logic lock);
    tile_hsel[t]              = sel;
    tile_hwrite[t]            = sel;
    tile_htrans[2*t +: 2]     = tr;
    tile_haddr[t*XLEN +: XLEN] = addr;
    tile_hmastlock[t]         = lock;
  endtask

  task automatic wait_ready(input int t, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (tile_hready[t]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard: every accepted external address phase must match the next expected address.
  always @(negedge clk) begin
    if (!rst && ext_hsel && ext_htrans == HTRANS_NONSEQ && ext_hready) begin
      if (exp_addr_q.size() == 0) begin
        check("ext_addr_unexpected", 64'(ext_haddr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("ext_addr", 64'(ext_haddr), 64'(exp_addr_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && glip_out_valid && glip_out_ready) begin
      if (glip_q.size() == 0) begin
        check("glip_resp_unexpected", 64'(glip_out_data), 64'h1_0000);
      end else begin
        check("glip_resp", 64'(glip_out_data), 64'(glip_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] word;
    logic        has_resp;
    logic [15:0] resp;
    logic        exp_rst;
    logic        exp_stall;
  } glip_vec_t;

  typedef struct {
    int          tile;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        resp;
  } xfer_vec_t;

  glip_vec_t gv[8];
  xfer_vec_t xv[5];

  initial begin
    bit ok;

    gv[0] = '{16'h1001, 1'b0, 16'h0000, DBG,  1'b0};
    gv[1] = '{16'h1000, 1'b0, 16'h0000, 1'b0, 1'b0};
    gv[2] = '{16'h2001, 1'b0, 16'h0000, 1'b0, DBG};
    gv[3] = '{16'h3000, DBG,  16'h3005, 1'b0, DBG};
    gv[4] = '{16'h7ABC, DBG,  16'hFFFF, 1'b0, DBG};
    gv[5] = '{16'h4ABC, DBG,  16'h4ABC, 1'b0, DBG};
    gv[6] = '{16'h2000, 1'b0, 16'h0000, 1'b0, 1'b0};
    gv[7] = '{16'h0123, DBG,  16'hFFFF, 1'b0, 1'b0};

    xv[0] = '{3, 32'h0000_3000, 32'h1234_5678, 1'b0};
    xv[1] = '{7, 32'h8000_0004, 32'hCAFE_F00D, 1'b1};
    xv[2] = '{0, 32'h0000_0010, 32'h0BAD_F00D, 1'b0};
    xv[3] = '{5, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 1'b0};
    xv[4] = '{6, 32'h7000_0000, 32'h0000_0001, 1'b1};

    #3;
    check("rst_sys_in_reset", rst_sys, 1);
    check("rst_cpu_in_reset", rst_cpu, 1);
    check("cpu_stall_reset", cpu_stall, 0);
    check("glip_out_valid_reset", glip_out_valid, 0);
    check("glip_out_data_reset", glip_out_data, 0);
    check("ext_htrans_reset", ext_htrans, HTRANS_IDLE);
    check("ext_hsel_reset", ext_hsel, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (gv[i]) begin
      @(posedge clk); #1;
      glip_in_data  = gv[i].word;
      glip_in_valid = 1'b1;
      if (gv[i].has_resp) glip_q.push_back(gv[i].resp);
      @(negedge clk);
      check("glip_in_ready", glip_in_ready, 1);
      @(posedge clk); #1;
      glip_in_valid = 1'b0;
      @(negedge clk);
      check("glip_rst_sys", rst_sys, gv[i].exp_rst);
      check("glip_cpu_stall", cpu_stall, gv[i].exp_stall);
      if (!gv[i].has_resp) check("glip_no_resp", glip_out_valid, 0);
    end

    // Response held under back-pressure blocks further input words.
    @(posedge clk); #1;
    glip_out_ready = 1'b0;
    glip_in_data   = 16'h3000;
    glip_in_valid  = 1'b1;
`ifdef MPSOC3D_DEBUG_EN
    glip_q.push_back(16'h3005);
`endif
    @(posedge clk); #1;
    glip_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("glip_hold_valid", glip_out_valid, DBG);
      check("glip_hold_in_ready", glip_in_ready, !DBG);
      @(posedge clk); #1;
    end
    glip_out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("glip_dropped", glip_out_valid, 0);
    check("glip_ready_again", glip_in_ready, 1);

    foreach (xv[i]) begin
      @(posedge clk); #1;
      set_tile(xv[i].tile, 1'b1, HTRANS_NONSEQ, xv[i].addr, 1'b0);
      exp_addr_q.push_back(xv[i].addr);
      wait_ready(xv[i].tile, ok);
      check("xfer_grant", ok, 1);
      @(posedge clk); #1;
      set_tile(xv[i].tile, 1'b0, HTRANS_IDLE, '0, 1'b0);
      tile_hwdata[xv[i].tile*XLEN +: XLEN] = xv[i].addr ^ 32'hA5A5_A5A5;
      ext_hrdata = xv[i].rdata;
      ext_hresp  = xv[i].resp;
      @(negedge clk);
      check("xfer_hwdata", ext_hwdata, xv[i].addr ^ 32'hA5A5_A5A5);
      check("xfer_hrdata", tile_hrdata[xv[i].tile*XLEN +: XLEN], xv[i].rdata);
      check("xfer_hresp", tile_hresp[xv[i].tile], xv[i].resp);
      check("xfer_other_hrdata", tile_hrdata[((xv[i].tile + 1) % NUMCTS)*XLEN +: XLEN], 0);
      @(posedge clk); #1;
      ext_hrdata = '0;
      ext_hresp  = 1'b0;
    end

    // Simultaneous requests from tiles 0 and 2 straight after reset.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    set_tile(0, 1'b1, HTRANS_NONSEQ, 32'h100, 1'b0);
    set_tile(2, 1'b1, HTRANS_NONSEQ, 32'h200, 1'b0);
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h200);
    @(negedge clk);
    check("rr_t0_wait", tile_hready[0], 0);
    check("rr_t2_wait0", tile_hready[2], 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_first_addr", ext_haddr, 32'h100);
    check("rr_t0_ready", tile_hready[0], 1);
    check("rr_t2_wait1", tile_hready[2], 0);
    @(posedge clk); #1;
    set_tile(0, 1'b0, HTRANS_IDLE, '0, 1'b0);
    ext_hrdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rr_t0_rdata", tile_hrdata[0 +: XLEN], 32'hDEAD_BEEF);
    check("rr_t2_rdata", tile_hrdata[2*XLEN +: XLEN], 0);
    check("rr_t2_wait2", tile_hready[2], 0);
    @(posedge clk); #1;
    ext_hrdata = '0;
    @(negedge clk);
    check("rr_second_addr", ext_haddr, 32'h200);
    check("rr_t2_ready", tile_hready[2], 1);
    @(posedge clk); #1;
    set_tile(2, 1'b0, HTRANS_IDLE, '0, 1'b0);

    // Locked owner keeps the bus until it unlocks while idle.
    @(posedge clk); #1;
    set_tile(1, 1'b1, HTRANS_NONSEQ, 32'h1111_0000, 1'b1);
    exp_addr_q.push_back(32'h1111_0000);
    wait_ready(1, ok);
    check("lock_grant_t1", ok, 1);
    @(posedge clk); #1;
    set_tile(1, 1'b1, HTRANS_IDLE, 32'h1111_0000, 1'b1);
    set_tile(3, 1'b1, HTRANS_NONSEQ, 32'h3333_0000, 1'b0);
    exp_addr_q.push_back(32'h3333_0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("lock_t3_blocked", tile_hready[3], 0);
      check("lock_ext_idle", ext_htrans, HTRANS_IDLE);
      check("lock_ext_mastlock", ext_hmastlock, 1);
      @(posedge clk); #1;
    end
    set_tile(1, 1'b0, HTRANS_IDLE, '0, 1'b0);
    wait_ready(3, ok);
    check("lock_grant_t3", ok, 1);
    @(posedge clk); #1;
    set_tile(3, 1'b0, HTRANS_IDLE, '0, 1'b0);

    // Reset while a tile owns the address phase.
    @(posedge clk); #1;
    set_tile(4, 1'b1, HTRANS_NONSEQ, 32'h4444_0000, 1'b0);
    @(posedge clk); #1;
    check("midrst_granted", ext_hsel, 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_hsel", ext_hsel, 0);
    check("midrst_htrans", ext_htrans, HTRANS_IDLE);
    set_tile(4, 1'b0, HTRANS_IDLE, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_hsel", ext_hsel, 0);

    @(posedge clk); #1;
    check("ext_queue_drained", exp_addr_q.size(), 0);
    check("glip_queue_drained", glip_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
